// File: rtl/pulse_logic_cell_if.sv
// Bundle for the pulse logic cell: toggle-encoded inputs, violation clear,
// and the result/status signals that come back from the cell.
interface pulse_logic_cell_if #(
  parameter int N     = 2,
  parameter int CNT_W = 8
);
  logic [N-1:0]     din;
  logic             evt;
  logic             viol_clr;
  logic             out;
  logic [N-1:0]     pending;
  logic             viol;
  logic [CNT_W-1:0] viol_cnt;

  modport master (
    output din, evt, viol_clr,
    input  out, pending, viol, viol_cnt
  );

  modport slave (
    input  din, evt, viol_clr,
    output out, pending, viol, viol_cnt
  );
endinterface

// File: rtl/pulse_logic_cell.sv
// Clocked emulation of a pulse-logic gate: toggle-encoded arrivals accumulate,
// a toggle-encoded eval fires XOR/OR/AND after a fixed delay, hold misses counted.
module pulse_logic_cell #(
  parameter int N          = 2,
  parameter int MODE       = 0,
  parameter int DELAY_CYC  = 5,
  parameter int HOLD_CYC   = 2,
  parameter int OUT_TOGGLE = 1,
  parameter int CNT_W      = 8
) (
  input logic              clk,
  input logic              rst_n,
  pulse_logic_cell_if.slave cell_if
);

  localparam int HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
  localparam int PW = $clog2(N + 1);
  localparam int SW = CNT_W + PW;

  logic                 armed_q, armed_d;
  logic [N-1:0]         dinHist_q, dinHist_d;
  logic                 evtHist_q, evtHist_d;
  logic [N-1:0]         pending_q, pending_d;
  logic [DELAY_CYC-1:0] pipe_q, pipe_d;
  logic                 out_q, out_d;
  logic [HW-1:0]        holdCnt_q, holdCnt_d;
  logic                 viol_q, viol_d;
  logic [CNT_W-1:0]     violCnt_q, violCnt_d;

  logic [N-1:0]  arrival;
  logic [N-1:0]  evalSet;
  logic [N-1:0]  violBits;
  logic [PW-1:0] setCnt;
  logic [PW-1:0] violCount;
  logic [SW-1:0] cntSum;
  logic          evalHit;
  logic          fireRaw;
  logic          fire;
  logic          holdActive;
  logic          emerge;

  // Same-edge arrivals join the evaluation they coincide with, so the
  // function is taken over pending OR arrivals, then pending is wiped.
  always_comb begin
    arrival    = armed_q ? (cell_if.din ^ dinHist_q) : '0;
    evalHit    = armed_q & (cell_if.evt ^ evtHist_q);
    evalSet    = pending_q | arrival;
    holdActive = (holdCnt_q != '0);
    violBits   = holdActive ? arrival : '0;

    setCnt    = '0;
    violCount = '0;
    for (int i = 0; i < N; i++) begin
      setCnt    = setCnt + PW'(evalSet[i]);
      violCount = violCount + PW'(violBits[i]);
    end

    if (MODE == 0)      fireRaw = setCnt[0];
    else if (MODE == 1) fireRaw = |evalSet;
    else                fireRaw = &evalSet;
    fire = evalHit & fireRaw;

    armed_d   = 1'b1;
    dinHist_d = cell_if.din;
    evtHist_d = cell_if.evt;
    pending_d = evalHit ? '0 : evalSet;

    pipe_d = (pipe_q << 1) | DELAY_CYC'(fire);
    emerge = pipe_q[DELAY_CYC-1];
    out_d  = (OUT_TOGGLE != 0) ? (out_q ^ emerge) : emerge;

    if (evalHit)         holdCnt_d = HW'(HOLD_CYC);
    else if (holdActive) holdCnt_d = holdCnt_q - HW'(1);
    else                 holdCnt_d = holdCnt_q;

    // A clear and a fresh violation in the same cycle: the violation survives.
    cntSum    = (cell_if.viol_clr ? SW'(0) : SW'(violCnt_q)) + SW'(violCount);
    violCnt_d = (cntSum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : cntSum[CNT_W-1:0];
    viol_d    = (cell_if.viol_clr ? 1'b0 : viol_q) | (violCount != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q   <= 1'b0;
      dinHist_q <= '0;
      evtHist_q <= 1'b0;
      pending_q <= '0;
      pipe_q    <= '0;
      out_q     <= 1'b0;
      holdCnt_q <= '0;
      viol_q    <= 1'b0;
      violCnt_q <= '0;
    end else begin
      armed_q   <= armed_d;
      dinHist_q <= dinHist_d;
      evtHist_q <= evtHist_d;
      pending_q <= pending_d;
      pipe_q    <= pipe_d;
      out_q     <= out_d;
      holdCnt_q <= holdCnt_d;
      viol_q    <= viol_d;
      violCnt_q <= violCnt_d;
    end
  end

  assign cell_if.out      = out_q;
  assign cell_if.pending  = pending_q;
  assign cell_if.viol     = viol_q;
  assign cell_if.viol_cnt = violCnt_q;

endmodule
